uart_tx_arbiter: RTL

//  Shares the single UART transmitter between NUM_REQ byte-stream requesters (BIP result dump, RX echo, debug).

---
 rtl/uart_tx_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Whole frames are granted round-robin: the owner keeps the grant until the
// byte tagged i_last has been sent, or until the watchdog forces a release.
//
// Handshake: a requester holds i_req[k] high with a byte on i_data[k]/i_last[k];
// the byte is consumed in the cycle o_ack[k] pulses, exactly once per byte.
// After o_ack the requester presents its next byte or drops i_req by the next
// cycle. i_data/i_last are only sampled when the ack is issued.
// Towards the UART, o_tx_start is held high with o_data_tx stable until a
// rising edge of i_tx_done reports the word as sent.
module uart_tx_arbiter #(
    parameter int NUM_REQ            = 2,
    parameter int OUTPUT_WORD_LENGTH = 8,
    parameter int TX_TIMEOUT         = 4096,
    parameter int TIMEOUT_LENGTH     = 13
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset,
    input  logic [NUM_REQ-1:0]                    i_req,
    input  logic [NUM_REQ*OUTPUT_WORD_LENGTH-1:0] i_data,
    input  logic [NUM_REQ-1:0]                    i_last,
    output logic [NUM_REQ-1:0]                    o_ack,
    output logic [NUM_REQ-1:0]                    o_grant,
    input  logic                                  i_tx_done,
    output logic                                  o_tx_start,
    output logic [OUTPUT_WORD_LENGTH-1:0]         o_data_tx,
    output logic                                  o_timeout,
    output logic [2:0]                            o_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TIMEOUT_LENGTH-1:0] TMO_LAST = TIMEOUT_LENGTH'(TX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SEND = 3'b010,
        ST_HOLD = 3'b100
    } state_e;

    state_e                          state_q, state_d;
    logic [NUM_REQ-1:0]              grant_q, grant_d;
    logic [NUM_REQ-1:0]              ack_q, ack_d;
    logic [OUTPUT_WORD_LENGTH-1:0]   data_q, data_d;
    logic                            last_q, last_d;
    logic                            done_q;
    logic [TIMEOUT_LENGTH-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]                owner_q, owner_d;
    logic                            timeout_q, timeout_d;

    logic                            done_edge;
    logic                            win_found;
    logic [PTR_W-1:0]                win_idx;
    logic [PTR_W-1:0]                sel_idx;
    logic [NUM_REQ-1:0]              sel_onehot;
    logic [OUTPUT_WORD_LENGTH-1:0]   sel_data;
    logic                            sel_last;
    logic                            owner_req;

    // A word counts as sent only on a fresh rising edge of the UART done flag.
    assign done_edge = i_tx_done & ~done_q;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!win_found && i_req[k] && (k == (int'(rr_ptr_q) + i) % NUM_REQ)) begin
                    win_found = 1'b1;
                    win_idx   = PTR_W'(k);
                end
            end
        end
    end

    // Pick the byte source: the arbitration winner in IDLE, the owner otherwise.
    always_comb begin
        sel_idx    = (state_q == ST_IDLE) ? win_idx : owner_q;
        sel_onehot = '0;
        sel_data   = '0;
        sel_last   = 1'b0;
        owner_req  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (PTR_W'(k) == sel_idx) begin
                sel_onehot[k] = 1'b1;
                sel_data      = i_data[k*OUTPUT_WORD_LENGTH +: OUTPUT_WORD_LENGTH];
                sel_last      = i_last[k];
            end
            if (PTR_W'(k) == owner_q) begin
                owner_req = i_req[k];
            end
        end
    end

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = '0;
        data_d    = data_q;
        last_d    = last_q;
        tmo_cnt_d = tmo_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (win_found) begin
                    state_d   = ST_SEND;
                    grant_d   = sel_onehot;
                    ack_d     = sel_onehot;
                    data_d    = sel_data;
                    last_d    = sel_last;
                    tmo_cnt_d = '0;
                    owner_d   = win_idx;
                end
            end
            ST_SEND: begin
                tmo_cnt_d = tmo_cnt_q + TIMEOUT_LENGTH'(1);
                if (done_edge) begin
                    if (last_q) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = owner_q;
                    end else begin
                        state_d   = ST_HOLD;
                        tmo_cnt_d = '0;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // UART never reported completion: give the transmitter back.
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = owner_q;
                    timeout_d = 1'b1;
                end
            end
            ST_HOLD: begin
                tmo_cnt_d = tmo_cnt_q + TIMEOUT_LENGTH'(1);
                if (owner_req) begin
                    state_d   = ST_SEND;
                    ack_d     = sel_onehot;
                    data_d    = sel_data;
                    last_d    = sel_last;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    // Owner stopped mid-frame: release so others are not starved.
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    rr_ptr_d  = owner_q;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_cnt_q <= '0;
            rr_ptr_q  <= PTR_W'(NUM_REQ - 1);
            owner_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            last_q    <= last_d;
            done_q    <= i_tx_done;
            tmo_cnt_q <= tmo_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_tx_start = (state_q == ST_SEND);
    assign o_grant    = grant_q;
    assign o_ack      = ack_q;
    assign o_data_tx  = data_q;
    assign o_timeout  = timeout_q;
    assign o_state    = state_q;

endmodule
